// File: rtl/occ_step_ctrl.sv
// One FM-index backward-search extension step: two Occ ROM reads plus C offset.
// Optional macro OCC_EMPTY_SKIP_EN answers already-empty intervals without ROM access.
module occ_step_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_base,
   input  logic [7:0]  req_k,
   input  logic [7:0]  req_l,
   input  logic [31:0] c_table,
   output logic        occ_ce,
   output logic [7:0]  occ_addr,
   input  logic [31:0] occ_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [7:0]  rsp_k,
   output logic [7:0]  rsp_l,
   output logic        rsp_empty,
   output logic        rsp_ovf
);

   typedef enum logic [1:0] {IDLE, RD_K, RD_L, RESP} state_t;

   state_t      state, state_nxt;
   logic [1:0]  base_q;
   logic [7:0]  k_q, l_q, cb_q, ok_q;
   logic [7:0]  lane_now;
   logic [8:0]  k9, l9;
   logic        skip_now;

   function automatic logic [7:0] lane_sel(input logic [31:0] w, input logic [1:0] b);
      case (b)
         2'd0:    lane_sel = w[7:0];
         2'd1:    lane_sel = w[15:8];
         2'd2:    lane_sel = w[23:16];
         default: lane_sel = w[31:24];
      endcase
   endfunction

   assign lane_now = lane_sel(occ_data, base_q);
   assign k9 = {1'b0, cb_q} + {1'b0, ok_q} + 9'd1;
   assign l9 = {1'b0, cb_q} + {1'b0, lane_now};

`ifdef OCC_EMPTY_SKIP_EN
   assign skip_now = (req_k > req_l);
`else
   assign skip_now = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      occ_ce    = 1'b0;
      occ_addr  = 8'h00;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = skip_now ? RESP : RD_K;
         end
         RD_K: begin
            occ_ce    = 1'b1;
            // k=0 wraps to 0xFF, where the ROM holds the -1 row (zero)
            occ_addr  = k_q - 8'd1;
            state_nxt = RD_L;
         end
         RD_L: begin
            occ_ce    = 1'b1;
            occ_addr  = l_q;
            state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         base_q    <= 2'd0;
         k_q       <= 8'h00;
         l_q       <= 8'h00;
         cb_q      <= 8'h00;
         ok_q      <= 8'h00;
         rsp_k     <= 8'h00;
         rsp_l     <= 8'h00;
         rsp_empty <= 1'b0;
         rsp_ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  base_q <= req_base;
                  k_q    <= req_k;
                  l_q    <= req_l;
                  cb_q   <= lane_sel(c_table, req_base);
                  if (skip_now) begin
                     rsp_k     <= req_k;
                     rsp_l     <= req_l;
                     rsp_empty <= 1'b1;
                     rsp_ovf   <= 1'b0;
                  end
               end
            end
            RD_K: ok_q <= lane_now;
            RD_L: begin
               rsp_k     <= k9[7:0];
               rsp_l     <= l9[7:0];
               rsp_ovf   <= k9[8] | l9[8];
               rsp_empty <= (k9 > l9);
            end
            default: ;
         endcase
      end
   end

endmodule
